// File: rtl/segre_pkg.sv
// Shared types and sizing for the cache-to-memory path of the segre core.
// Holds the cache/memory request format, cache identifiers and arbiter FSM states.
package segre_pkg;

  localparam int unsigned WORD_SIZE            = 32;
  localparam int unsigned CACHE_LINE_SIZE_BITS = 128;
  localparam int unsigned ARB_BUF_SIZE         = 16;
  localparam int unsigned ARB_PTR_SIZE         = $clog2(ARB_BUF_SIZE);

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } cache_id_e;

  typedef struct packed {
    logic                            rd;
    logic                            wr;
    logic [WORD_SIZE-1:0]            addr;
    logic [CACHE_LINE_SIZE_BITS-1:0] line;
    cache_id_e                       cache_id;
  } cache_mem_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_e;

  function automatic cache_id_e other_cache(input cache_id_e id);
    return (id == ICACHE) ? DCACHE : ICACHE;
  endfunction

endpackage

// File: rtl/segre_arb_fifo.sv
// Synchronous FIFO of cache_mem_req_t used as the arbiter request queue.
// BUF_SIZE must be a power of two so the pointers wrap naturally.
module segre_arb_fifo
  import segre_pkg::*;
#(
  parameter int unsigned BUF_SIZE = ARB_BUF_SIZE,
  parameter int unsigned PTR_SIZE = ARB_PTR_SIZE
) (
  input  logic           clk_i,
  input  logic           rsn_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  cache_mem_req_t data_i,
  output cache_mem_req_t head_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam logic [PTR_SIZE:0] FullCount = (PTR_SIZE+1)'(BUF_SIZE);

  cache_mem_req_t      mem_q [BUF_SIZE];
  logic [PTR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_SIZE:0]   count_q, count_d;
  logic                do_push, do_pop;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_SIZE'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_SIZE'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_SIZE+1)'(1);
      2'b01:   count_d = count_q - (PTR_SIZE+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/segre_mem_arbiter.sv
// Serialises icache/dcache line requests onto the single main-memory port.
// Define SEGRE_ARB_DCACHE_PRIO_EN for fixed dcache priority instead of round-robin.
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int unsigned BUF_SIZE = ARB_BUF_SIZE,
  parameter int unsigned PTR_SIZE = ARB_PTR_SIZE
) (
  input  logic                            clk_i,
  input  logic                            rsn_i,
  input  logic                            ic_req_i,
  input  logic [WORD_SIZE-1:0]            ic_addr_i,
  output logic                            ic_ready_o,
  input  logic                            dc_req_i,
  input  logic                            dc_rd_i,
  input  logic                            dc_wr_i,
  input  logic [WORD_SIZE-1:0]            dc_addr_i,
  input  logic [CACHE_LINE_SIZE_BITS-1:0] dc_line_i,
  output logic                            dc_ready_o,
  output logic                            mem_req_o,
  output logic                            mem_rd_o,
  output logic                            mem_wr_o,
  output logic [WORD_SIZE-1:0]            mem_addr_o,
  output logic [CACHE_LINE_SIZE_BITS-1:0] mem_line_o,
  input  logic                            mem_rsp_valid_i,
  input  logic [CACHE_LINE_SIZE_BITS-1:0] mem_rsp_line_i,
  output logic                            ic_rsp_valid_o,
  output logic                            dc_rsp_valid_o,
  output logic [CACHE_LINE_SIZE_BITS-1:0] rsp_line_o
);

  arb_state_e                      state_q, state_d;
  cache_mem_req_t                  ic_entry, dc_entry, push_data, head;
  logic                            ic_grant, dc_grant, push, pop, full, empty, busy;
  logic                            ic_rsp_q, ic_rsp_d, dc_rsp_q, dc_rsp_d;
  logic [CACHE_LINE_SIZE_BITS-1:0] rsp_line_q, rsp_line_d;

  always_comb begin
    ic_entry          = '0;
    ic_entry.rd       = 1'b1;
    ic_entry.wr       = 1'b0;
    ic_entry.addr     = ic_addr_i;
    ic_entry.cache_id = ICACHE;

    // Illegal rd/wr combinations are queued as-is; the assertion below flags them.
    dc_entry          = '0;
    dc_entry.rd       = dc_rd_i;
    dc_entry.wr       = dc_wr_i;
    dc_entry.addr     = dc_addr_i;
    dc_entry.line     = dc_line_i;
    dc_entry.cache_id = DCACHE;
  end

`ifdef SEGRE_ARB_DCACHE_PRIO_EN
  always_comb begin
    ic_grant = 1'b0;
    dc_grant = 1'b0;
    if (!full) begin
      if (dc_req_i)      dc_grant = 1'b1;
      else if (ic_req_i) ic_grant = 1'b1;
    end
  end
`else
  // rr_q names the source favoured on the next contested cycle.
  cache_id_e rr_q, rr_d;

  always_comb begin
    ic_grant = 1'b0;
    dc_grant = 1'b0;
    if (!full) begin
      if (ic_req_i && dc_req_i) begin
        if (rr_q == ICACHE) ic_grant = 1'b1;
        else                dc_grant = 1'b1;
      end else if (ic_req_i) begin
        ic_grant = 1'b1;
      end else if (dc_req_i) begin
        dc_grant = 1'b1;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (ic_grant)      rr_d = other_cache(ICACHE);
    else if (dc_grant) rr_d = other_cache(DCACHE);
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) rr_q <= ICACHE;
    else        rr_q <= rr_d;
  end
`endif

  assign ic_ready_o = ic_grant;
  assign dc_ready_o = dc_grant;
  assign push       = ic_grant || dc_grant;
  assign push_data  = dc_grant ? dc_entry : ic_entry;

  segre_arb_fifo #(
    .BUF_SIZE (BUF_SIZE),
    .PTR_SIZE (PTR_SIZE)
  ) u_fifo (
    .clk_i   (clk_i),
    .rsn_i   (rsn_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_data),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    ic_rsp_d   = 1'b0;
    dc_rsp_d   = 1'b0;
    rsp_line_d = rsp_line_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (!empty) state_d = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mem_rsp_valid_i) begin
          pop        = 1'b1;
          state_d    = ARB_IDLE;
          ic_rsp_d   = (head.cache_id == ICACHE);
          dc_rsp_d   = (head.cache_id == DCACHE);
          rsp_line_d = mem_rsp_line_i;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q    <= ARB_IDLE;
      ic_rsp_q   <= 1'b0;
      dc_rsp_q   <= 1'b0;
      rsp_line_q <= '0;
    end else begin
      state_q    <= state_d;
      ic_rsp_q   <= ic_rsp_d;
      dc_rsp_q   <= dc_rsp_d;
      rsp_line_q <= rsp_line_d;
    end
  end

  // The head is stable from ISSUE through WAIT, so it drives the port directly.
  assign busy       = (state_q != ARB_IDLE);
  assign mem_req_o  = (state_q == ARB_ISSUE);
  assign mem_rd_o   = busy && head.rd;
  assign mem_wr_o   = busy && head.wr;
  assign mem_addr_o = busy ? head.addr : '0;
  assign mem_line_o = busy ? head.line : '0;

  assign ic_rsp_valid_o = ic_rsp_q;
  assign dc_rsp_valid_o = dc_rsp_q;
  assign rsp_line_o     = rsp_line_q;

  dc_req_legal_a: assert property (@(posedge clk_i) disable iff (!rsn_i)
    dc_req_i |-> (dc_rd_i ^ dc_wr_i));

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Self-checking bench for segre_mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level queue model.
module tb_segre_mem_arbiter;
  import segre_pkg::*;

  localparam int unsigned Depth = ARB_BUF_SIZE;
  localparam logic [CACHE_LINE_SIZE_BITS-1:0] TestLine =
    128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

  logic                            clk_i = 1'b0;
  logic                            rsn_i;
  logic                            ic_req_i, ic_ready_o;
  logic [WORD_SIZE-1:0]            ic_addr_i;
  logic                            dc_req_i, dc_rd_i, dc_wr_i, dc_ready_o;
  logic [WORD_SIZE-1:0]            dc_addr_i;
  logic [CACHE_LINE_SIZE_BITS-1:0] dc_line_i;
  logic                            mem_req_o, mem_rd_o, mem_wr_o;
  logic [WORD_SIZE-1:0]            mem_addr_o;
  logic [CACHE_LINE_SIZE_BITS-1:0] mem_line_o;
  logic                            mem_rsp_valid_i;
  logic [CACHE_LINE_SIZE_BITS-1:0] mem_rsp_line_i;
  logic                            ic_rsp_valid_o, dc_rsp_valid_o;
  logic [CACHE_LINE_SIZE_BITS-1:0] rsp_line_o;

  always #5 clk_i = ~clk_i;

  segre_mem_arbiter dut (
    .clk_i           (clk_i),
    .rsn_i           (rsn_i),
    .ic_req_i        (ic_req_i),
    .ic_addr_i       (ic_addr_i),
    .ic_ready_o      (ic_ready_o),
    .dc_req_i        (dc_req_i),
    .dc_rd_i         (dc_rd_i),
    .dc_wr_i         (dc_wr_i),
    .dc_addr_i       (dc_addr_i),
    .dc_line_i       (dc_line_i),
    .dc_ready_o      (dc_ready_o),
    .mem_req_o       (mem_req_o),
    .mem_rd_o        (mem_rd_o),
    .mem_wr_o        (mem_wr_o),
    .mem_addr_o      (mem_addr_o),
    .mem_line_o      (mem_line_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_line_i  (mem_rsp_line_i),
    .ic_rsp_valid_o  (ic_rsp_valid_o),
    .dc_rsp_valid_o  (dc_rsp_valid_o),
    .rsp_line_o      (rsp_line_o)
  );

  typedef struct {
    bit                              is_dc;
    bit                              rd;
    bit                              wr;
    logic [WORD_SIZE-1:0]            addr;
    logic [CACHE_LINE_SIZE_BITS-1:0] line;
  } txn_t;

  // Reference model: queued transactions plus the timing facts needed to predict the port.
  txn_t        mq[$];
  bit          pref_dc, busy_prev, hold_prev;
  int unsigned size_prev;
  bit          exp_ic_rsp, exp_dc_rsp, exp_line_chk;
  logic [CACHE_LINE_SIZE_BITS-1:0] exp_line;

  int vectors, miscompares, n_done, n_dc_acc;

  bit                              s_ic_req, s_dc_req, s_dc_rd, s_dc_wr, s_rsp_en, s_rsp_force;
  logic [WORD_SIZE-1:0]            s_ic_addr, s_dc_addr;
  logic [CACHE_LINE_SIZE_BITS-1:0] s_dc_line, s_rsp_line;

  task automatic chk(input string tag, input logic [CACHE_LINE_SIZE_BITS-1:0] got,
                     input logic [CACHE_LINE_SIZE_BITS-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CACHE_LINE_SIZE_BITS-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic new_ic();
    s_ic_req  = 1'b1;
    s_ic_addr = $urandom();
  endtask

  task automatic new_dc(input bit wr);
    s_dc_req  = 1'b1;
    s_dc_wr   = wr;
    s_dc_rd   = !wr;
    s_dc_addr = $urandom();
    s_dc_line = rand_line();
  endtask

  task automatic model_reset();
    mq.delete();
    pref_dc      = 1'b0;
    busy_prev    = 1'b0;
    hold_prev    = 1'b0;
    size_prev    = 0;
    exp_ic_rsp   = 1'b0;
    exp_dc_rsp   = 1'b0;
    exp_line_chk = 1'b0;
    s_ic_req     = 1'b0;
    s_dc_req     = 1'b0;
    s_rsp_en     = 1'b0;
    s_rsp_force  = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk_i);
    rsn_i           = 1'b0;
    ic_req_i        = 1'b0;
    dc_req_i        = 1'b0;
    dc_rd_i         = 1'b0;
    dc_wr_i         = 1'b0;
    mem_rsp_valid_i = 1'b0;
    #1;
    chk("rst_ic_ready", ic_ready_o, 0);
    chk("rst_dc_ready", dc_ready_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_rd", mem_rd_o, 0);
    chk("rst_mem_wr", mem_wr_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_line", mem_line_o, 0);
    chk("rst_ic_rsp", ic_rsp_valid_o, 0);
    chk("rst_dc_rsp", dc_rsp_valid_o, 0);
    chk("rst_rsp_line", rsp_line_o, 0);
    chk("rst_count", dut.u_fifo.count_q, 0);
    repeat (2) @(negedge clk_i);
    rsn_i = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive, compare against the model, then advance the model past the edge.
  task automatic cycle();
    bit          exp_req, busy_now, wait_now, ic_g, dc_g, rsp;
    int unsigned size_now;
    txn_t        t;
    size_now = mq.size();
    exp_req  = !busy_prev && (size_prev > 0);
    busy_now = exp_req || hold_prev;
    wait_now = busy_now && !exp_req;
    rsp      = s_rsp_force || (s_rsp_en && wait_now);

    @(negedge clk_i);
    ic_req_i        = s_ic_req;
    ic_addr_i       = s_ic_addr;
    dc_req_i        = s_dc_req;
    dc_rd_i         = s_dc_rd;
    dc_wr_i         = s_dc_wr;
    dc_addr_i       = s_dc_addr;
    dc_line_i       = s_dc_line;
    mem_rsp_valid_i = rsp;
    mem_rsp_line_i  = s_rsp_line;
    #1;

    ic_g = 1'b0;
    dc_g = 1'b0;
    if (size_now < Depth) begin
`ifdef SEGRE_ARB_DCACHE_PRIO_EN
      if (s_dc_req)      dc_g = 1'b1;
      else if (s_ic_req) ic_g = 1'b1;
`else
      if (s_ic_req && s_dc_req) begin
        if (pref_dc) dc_g = 1'b1;
        else         ic_g = 1'b1;
      end else if (s_ic_req) begin
        ic_g = 1'b1;
      end else if (s_dc_req) begin
        dc_g = 1'b1;
      end
`endif
    end
    chk("ic_ready", ic_ready_o, ic_g);
    chk("dc_ready", dc_ready_o, dc_g);
    chk("mem_req", mem_req_o, exp_req);
    if (busy_now && mq.size() > 0) begin
      t = mq[0];
      chk("mem_rd", mem_rd_o, t.rd);
      chk("mem_wr", mem_wr_o, t.wr);
      chk("mem_addr", mem_addr_o, t.addr);
      if (t.wr) chk("mem_line", mem_line_o, t.line);
    end
    chk("ic_rsp", ic_rsp_valid_o, exp_ic_rsp);
    chk("dc_rsp", dc_rsp_valid_o, exp_dc_rsp);
    if (exp_line_chk) chk("rsp_line", rsp_line_o, exp_line);

    exp_ic_rsp   = 1'b0;
    exp_dc_rsp   = 1'b0;
    exp_line_chk = 1'b0;
    if (wait_now && rsp && mq.size() > 0) begin
      t            = mq.pop_front();
      exp_ic_rsp   = !t.is_dc;
      exp_dc_rsp   = t.is_dc;
      exp_line_chk = t.rd && !t.wr;
      exp_line     = s_rsp_line;
      n_done++;
    end
    if (ic_g) begin
      mq.push_back('{1'b0, 1'b1, 1'b0, s_ic_addr, '0});
      s_ic_req = 1'b0;
      pref_dc  = 1'b1;
    end
    if (dc_g) begin
      mq.push_back('{1'b1, s_dc_rd, s_dc_wr, s_dc_addr, s_dc_line});
      s_dc_req = 1'b0;
      pref_dc  = 1'b0;
      n_dc_acc++;
    end
    hold_prev   = busy_now && !(wait_now && rsp);
    busy_prev   = busy_now;
    size_prev   = size_now;
    s_rsp_force = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      s_rsp_en   = ($urandom_range(0, 1) == 1);
      s_rsp_line = rand_line();
      cycle();
      done = (mq.size() == 0) && !busy_prev && !s_ic_req && !s_dc_req &&
             !exp_ic_rsp && !exp_dc_rsp;
    end
    s_rsp_en = 1'b0;
    chk("drain_left", mq.size(), 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    n_done      = 0;
    n_dc_acc    = 0;
    s_ic_addr   = '0;
    s_dc_addr   = '0;
    s_dc_rd     = 1'b0;
    s_dc_wr     = 1'b0;
    s_dc_line   = '0;
    s_rsp_line  = '0;
    ic_addr_i   = '0;
    dc_addr_i   = '0;
    dc_line_i   = '0;
    mem_rsp_line_i = '0;
    model_reset();
    reset_dut();

    // Single icache read: issue at cycle 2, response at cycle 5, delivery at cycle 6.
    s_ic_req  = 1'b1;
    s_ic_addr = 32'h0000_1000;
    repeat (5) cycle();
    s_rsp_en   = 1'b1;
    s_rsp_line = TestLine;
    cycle();
    s_rsp_en = 1'b0;
    cycle();
    chk("t1_ic_rsp", ic_rsp_valid_o, 1);
    chk("t1_dc_rsp", dc_rsp_valid_o, 0);
    chk("t1_line", rsp_line_o, TestLine);

`ifndef SEGRE_ARB_DCACHE_PRIO_EN
    // Contested requests alternate starting with the icache.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      if (!s_ic_req) new_ic();
      if (!s_dc_req) new_dc($urandom_range(0, 1) == 1);
      cycle();
      chk("rr_ic_grant", ic_ready_o, (i % 2 == 0));
      chk("rr_dc_grant", dc_ready_o, (i % 2 == 1));
    end
    drain(200);
`else
    // Fixed priority: dcache always wins while it requests.
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      if (!s_ic_req) new_ic();
      if (!s_dc_req) new_dc($urandom_range(0, 1) == 1);
      cycle();
      chk("prio_ic_grant", ic_ready_o, 0);
      chk("prio_dc_grant", dc_ready_o, 1);
    end
    drain(300);
`endif

    // 17 dcache writes with memory stalled: the 17th waits for a pop.
    reset_dut();
    n_dc_acc = 0;
    for (int i = 0; i < 40 && n_dc_acc < 16; i++) begin
      if (!s_dc_req) new_dc(1'b1);
      cycle();
    end
    chk("full_accepted", n_dc_acc, 16);
    if (!s_dc_req) new_dc(1'b1);
    repeat (3) begin
      cycle();
      chk("full_blocked", dc_ready_o, 0);
    end
    s_rsp_en   = 1'b1;
    s_rsp_line = rand_line();
    cycle();
    chk("full_pop_cycle", dc_ready_o, 0);
    s_rsp_en = 1'b0;
    cycle();
    chk("full_after_pop", dc_ready_o, 1);
    drain(400);

    // Randomized traffic across many pointer wraps.
    reset_dut();
    n_done = 0;
    for (int c = 0; c < 700; c++) begin
      if (!s_ic_req && $urandom_range(0, 2) == 0) new_ic();
      if (!s_dc_req && $urandom_range(0, 2) == 0) new_dc($urandom_range(0, 1) == 1);
      s_rsp_en   = ($urandom_range(0, 3) == 0);
      s_rsp_line = rand_line();
      cycle();
    end
    drain(600);
    chk("rand_enough_txns", (n_done >= 40), 1);

    // Reset while waiting on memory with three entries queued.
    reset_dut();
    new_ic();
    cycle();
    new_dc(1'b0);
    cycle();
    new_dc(1'b1);
    repeat (4) cycle();
    chk("midrst_queued", mq.size(), 3);
    reset_dut();
    s_rsp_force = 1'b1;
    s_rsp_line  = rand_line();
    cycle();
    repeat (4) cycle();
    chk("midrst_no_ic_rsp", ic_rsp_valid_o, 0);
    chk("midrst_no_dc_rsp", dc_rsp_valid_o, 0);
    chk("midrst_count", dut.u_fifo.count_q, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
